// File: rtl/tlb_pkg.sv
// Shared types and CSR field positions for the TLB management sequencer.
// The packed tlb_entry_t layout is the bit format used on the tlb write and read ports.
package tlb_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_SRCH = 3'd1,
        OP_RD   = 3'd2,
        OP_WR   = 3'd3,
        OP_FILL = 3'd4,
        OP_INV  = 3'd5
    } op_code_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    localparam int ENTRY_W = $bits(tlb_entry_t);

    // Field offsets within the packed entry, MSB first.
    localparam int ENT_VPPN_LO = ENTRY_W - 19;
    localparam int ENT_PS_LO   = ENT_VPPN_LO - 6;
    localparam int ENT_G       = ENT_PS_LO - 1;
    localparam int ENT_ASID_LO = ENT_G - 10;
    localparam int ENT_E       = ENT_ASID_LO - 1;
    localparam int ENT_P0_LO   = ENT_E - $bits(tlb_page_t);
    localparam int ENT_P1_LO   = 0;

    localparam int TLBIDX_NE   = 31;
    localparam int TLBIDX_PS_HI = 29;
    localparam int TLBIDX_PS_LO = 24;
    localparam int EHI_VPPN_LO = 13;
    localparam int ELO_V       = 0;
    localparam int ELO_D       = 1;
    localparam int ELO_PLV_LO  = 2;
    localparam int ELO_MAT_LO  = 4;
    localparam int ELO_G       = 6;
    localparam int ELO_PPN_LO  = 8;

    localparam int PS_4K = 12;
    localparam int PS_4M = 21;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    typedef struct packed {
        logic        err;
        logic [3:0]  wmask;
        logic        tlbidx_we;
        logic [31:0] tlbidx;
        logic [31:0] ehi;
        logic [31:0] elo0;
        logic [31:0] elo1;
        logic [9:0]  asid;
    } rsp_t;

    function automatic tlb_page_t elo_to_page(input logic [31:0] elo);
        tlb_page_t p;
        p.ppn = elo[ELO_PPN_LO+:20];
        p.plv = elo[ELO_PLV_LO+:2];
        p.mat = elo[ELO_MAT_LO+:2];
        p.d   = elo[ELO_D];
        p.v   = elo[ELO_V];
        return p;
    endfunction

    function automatic logic [31:0] page_to_elo(input tlb_page_t p, input logic g);
        logic [31:0] r;
        r                 = '0;
        r[ELO_PPN_LO+:20] = p.ppn;
        r[ELO_G]          = g;
        r[ELO_MAT_LO+:2]  = p.mat;
        r[ELO_PLV_LO+:2]  = p.plv;
        r[ELO_D]          = p.d;
        r[ELO_V]          = p.v;
        return r;
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// Request/response channel between the pipeline/CSR side and tlb_op_ctrl.
// master = pipeline and CSR file, slave = the sequencer.
interface tlb_op_ctrl_if;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_code;
    logic [4:0]  inv_op;
    logic [9:0]  inv_asid;
    logic [18:0] inv_vppn;
    logic [31:0] csr_tlbidx;
    logic [31:0] csr_tlbehi;
    logic [31:0] csr_tlbelo0;
    logic [31:0] csr_tlbelo1;
    logic [9:0]  csr_asid;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_err;
    logic [3:0]  rsp_wmask;
    logic        rsp_tlbidx_we;
    logic [31:0] rsp_tlbidx;
    logic [31:0] rsp_tlbehi;
    logic [31:0] rsp_tlbelo0;
    logic [31:0] rsp_tlbelo1;
    logic [9:0]  rsp_asid;

    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, rsp_ready,
        input  op_ready, rsp_valid, rsp_err, rsp_wmask, rsp_tlbidx_we,
               rsp_tlbidx, rsp_tlbehi, rsp_tlbelo0, rsp_tlbelo1, rsp_asid
    );

    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_vppn,
               csr_tlbidx, csr_tlbehi, csr_tlbelo0, csr_tlbelo1, csr_asid, rsp_ready,
        output op_ready, rsp_valid, rsp_err, rsp_wmask, rsp_tlbidx_we,
               rsp_tlbidx, rsp_tlbehi, rsp_tlbelo0, rsp_tlbelo1, rsp_asid
    );
endinterface

// File: rtl/tlb_fill_idx_gen.sv
// TLBFILL replacement index: free-running, advances every clock.
// TLB_FILL_LFSR_EN selects a 4-bit Galois LFSR (x^4+x^3+1); otherwise a mod-TLBNUM counter.
module tlb_fill_idx_gen #(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [IW-1:0] fill_idx
);

`ifdef TLB_FILL_LFSR_EN
    if (TLBNUM != 16) begin : g_bad_tlbnum
        $error("tlb_fill_idx_gen: TLB_FILL_LFSR_EN requires TLBNUM == 16");
    end

    // Right-shifting Galois form; the seed is nonzero so the state never reaches 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) fill_idx <= IW'(1);
        else         fill_idx <= (fill_idx >> 1) ^ (fill_idx[0] ? IW'(4'hC) : '0);
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          fill_idx <= '0;
        else if (fill_idx == IW'(TLBNUM - 1)) fill_idx <= '0;
        else                                  fill_idx <= fill_idx + IW'(1);
    end
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// Executes one LoongArch TLB management instruction at a time (IDLE -> EXEC -> RESP).
// The TLBFILL index source is chosen by TLB_FILL_LFSR_EN inside tlb_fill_idx_gen.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter  int TLBNUM = 16,
    localparam int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    tlb_op_ctrl_if.slave  bus,
    output logic [18:0]   tlb_s_vppn,
    output logic [9:0]    tlb_s_asid,
    input  logic          tlb_s_found,
    input  logic [IW-1:0] tlb_s_index,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output tlb_entry_t    tlb_w_entry,
    output logic          tlb_inv_valid,
    output logic [4:0]    tlb_inv_op,
    output logic [IW-1:0] tlb_r_index,
    input  tlb_entry_t    tlb_r_entry
);

    state_e        state_q, state_d;
    op_code_e      op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q;
    logic [18:0]   inv_vppn_q;
    logic [31:0]   tlbidx_q;
    logic [18:0]   vppn_q;
    tlb_page_t     page0_q, page1_q;
    logic          g_q;
    logic [9:0]    asid_q;
    logic [IW-1:0] fill_q;
    logic [IW-1:0] fill_idx;
    rsp_t          rsp_q, rsp_d;
    logic          accept;

    tlb_fill_idx_gen #(.TLBNUM(TLBNUM)) u_fill_idx_gen (
        .clk      (clk),
        .resetn   (resetn),
        .fill_idx (fill_idx)
    );

    assign bus.op_ready = (state_q == S_IDLE);
    assign accept       = bus.op_valid && bus.op_ready;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Only the CSR fields the operations consume are kept; fill_q takes the pre-advance index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q       <= OP_NONE;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            tlbidx_q   <= '0;
            vppn_q     <= '0;
            page0_q    <= '0;
            page1_q    <= '0;
            g_q        <= 1'b0;
            asid_q     <= '0;
            fill_q     <= '0;
        end else if (accept) begin
            op_q       <= op_code_e'(bus.op_code);
            inv_op_q   <= bus.inv_op;
            inv_asid_q <= bus.inv_asid;
            inv_vppn_q <= bus.inv_vppn;
            tlbidx_q   <= bus.csr_tlbidx;
            vppn_q     <= bus.csr_tlbehi[31:EHI_VPPN_LO];
            page0_q    <= elo_to_page(bus.csr_tlbelo0);
            page1_q    <= elo_to_page(bus.csr_tlbelo1);
            g_q        <= bus.csr_tlbelo0[ELO_G] & bus.csr_tlbelo1[ELO_G];
            asid_q     <= bus.csr_asid;
            fill_q     <= fill_idx;
        end
    end

    // NOTE: every output and rsp_d gets a default first, so no path leaves a latch behind.
    always_comb begin
        tlb_s_vppn    = '0;
        tlb_s_asid    = '0;
        tlb_we        = 1'b0;
        tlb_w_index   = '0;
        tlb_w_entry   = '0;
        tlb_inv_valid = 1'b0;
        tlb_inv_op    = '0;
        tlb_r_index   = '0;
        rsp_d         = '0;
        rsp_d.tlbidx  = tlbidx_q;

        if (state_q == S_EXEC) begin
            case (op_q)
                OP_SRCH: begin
                    tlb_s_vppn             = vppn_q;
                    tlb_s_asid             = asid_q;
                    rsp_d.tlbidx_we        = 1'b1;
                    rsp_d.tlbidx[TLBIDX_NE] = !tlb_s_found;
                    if (tlb_s_found) rsp_d.tlbidx[IW-1:0] = tlb_s_index;
                end
                OP_RD: begin
                    tlb_r_index     = tlbidx_q[IW-1:0];
                    rsp_d.wmask     = 4'hF;
                    rsp_d.tlbidx_we = 1'b1;
                    rsp_d.tlbidx[TLBIDX_PS_HI:TLBIDX_PS_LO] = '0;
                    if (tlb_r_entry.e) begin
                        rsp_d.tlbidx[TLBIDX_NE] = 1'b0;
                        rsp_d.tlbidx[TLBIDX_PS_HI:TLBIDX_PS_LO] = tlb_r_entry.ps;
                        rsp_d.ehi  = {tlb_r_entry.vppn, 13'b0};
                        rsp_d.elo0 = page_to_elo(tlb_r_entry.p0, tlb_r_entry.g);
                        rsp_d.elo1 = page_to_elo(tlb_r_entry.p1, tlb_r_entry.g);
                        rsp_d.asid = tlb_r_entry.asid;
                    end else begin
                        rsp_d.tlbidx[TLBIDX_NE] = 1'b1;
                    end
                end
                OP_WR, OP_FILL: begin
                    tlb_we           = 1'b1;
                    tlb_w_index      = (op_q == OP_FILL) ? fill_q : tlbidx_q[IW-1:0];
                    tlb_w_entry.vppn = vppn_q;
                    tlb_w_entry.ps   = tlbidx_q[TLBIDX_PS_HI:TLBIDX_PS_LO];
                    tlb_w_entry.g    = g_q;
                    tlb_w_entry.asid = asid_q;
                    tlb_w_entry.e    = !tlbidx_q[TLBIDX_NE];
                    tlb_w_entry.p0   = page0_q;
                    tlb_w_entry.p1   = page1_q;
                end
                OP_INV: begin
                    if (inv_op_q <= INV_OP_MAX) begin
                        tlb_inv_valid = 1'b1;
                        tlb_inv_op    = inv_op_q;
                        tlb_s_vppn    = inv_vppn_q;
                        tlb_s_asid    = inv_asid_q;
                    end else begin
                        rsp_d.err = 1'b1;
                    end
                end
                default: rsp_d.err = 1'b1;
            endcase
        end
    end

    // The response image is cleared on handshake so rsp_* read 0 whenever rsp_valid is low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  rsp_q <= '0;
        else if (state_q == S_EXEC)                   rsp_q <= rsp_d;
        else if (state_q == S_RESP && bus.rsp_ready)  rsp_q <= '0;
    end

    assign bus.rsp_valid     = (state_q == S_RESP);
    assign bus.rsp_err       = rsp_q.err;
    assign bus.rsp_wmask     = rsp_q.wmask;
    assign bus.rsp_tlbidx_we = rsp_q.tlbidx_we;
    assign bus.rsp_tlbidx    = rsp_q.tlbidx;
    assign bus.rsp_tlbehi    = rsp_q.ehi;
    assign bus.rsp_tlbelo0   = rsp_q.elo0;
    assign bus.rsp_tlbelo1   = rsp_q.elo1;
    assign bus.rsp_asid      = rsp_q.asid;

endmodule
